// File: rtl/generic_fifo_write_packer_if.sv
// Handshake bundle between the narrow beat source, the packer and the
// downstream FIFO write port.  The packer uses the slave modport; the
// beat source / FIFO model side uses the master modport.
interface generic_fifo_write_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = $clog2(RATIO + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 write;
    logic [OUT_WIDTH-1:0] write_data;
    logic [LANE_W-1:0]    write_lanes;
    logic                 write_last;
    logic                 almost_full;

    modport master (
        output in_valid, in_data, in_last, almost_full,
        input  in_ready, write, write_data, write_lanes, write_last
    );

    modport slave (
        input  in_valid, in_data, in_last, almost_full,
        output in_ready, write, write_data, write_lanes, write_last
    );
endinterface

// File: rtl/generic_fifo_write_packer.sv
// generic_fifo_write_packer
// Packs RATIO narrow beats (first beat in the LSB lane) into one FIFO word
// and writes it with a valid-lane count and a packet-last flag.  A partial
// word is flushed, zero padded, on in_last.  almost_full sampled in the
// completion cycle parks the finished word in HOLD until the FIFO drains.
// Optional feature macro: GENERIC_FIFO_PACKER_TIMEOUT_EN (idle auto-flush).
module generic_fifo_write_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic clk,
    input  logic reset_poweron_n,
    input  logic clear,
    generic_fifo_write_packer_if.slave bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = $clog2(RATIO + 1);
    // An illegal configuration never accepts beats rather than misbehaving.
    localparam bit PARAMS_OK = (RATIO >= 2) && (TIMEOUT >= 1);

    typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [LANE_W-1:0]    count_r, count_s;
    logic [OUT_WIDTH-1:0] acc_r, acc_s;
    logic [OUT_WIDTH-1:0] hold_data_r, hold_data_s;
    logic [LANE_W-1:0]    hold_lanes_r, hold_lanes_s;
    logic                 hold_last_r, hold_last_s;
    logic                 write_r, write_s;
    logic [OUT_WIDTH-1:0] write_data_r, write_data_s;
    logic [LANE_W-1:0]    write_lanes_r, write_lanes_s;
    logic                 write_last_r, write_last_s;

    logic                 ready_s;
    logic                 accept_s;
    logic                 complete_s;
    logic [OUT_WIDTH-1:0] word_s;
    logic [LANE_W-1:0]    word_lanes_s;
    logic                 word_last_s;
    logic                 timeout_s;

`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_r, idle_s;
`endif

    // Beats are refused while reset/clear is active and while a word is parked.
    assign ready_s      = PARAMS_OK && reset_poweron_n && !clear && (state_r == FILL);
    assign accept_s     = bus.in_valid && ready_s;
    assign bus.in_ready = ready_s;

    assign bus.write       = write_r;
    assign bus.write_data  = write_data_r;
    assign bus.write_lanes = write_lanes_r;
    assign bus.write_last  = write_last_r;

    // Next-state, accumulator, hold latch and write-port decode.
    always_comb begin
        state_s       = state_r;
        count_s       = count_r;
        acc_s         = acc_r;
        hold_data_s   = hold_data_r;
        hold_lanes_s  = hold_lanes_r;
        hold_last_s   = hold_last_r;
        write_s       = 1'b0;
        write_data_s  = write_data_r;
        write_lanes_s = write_lanes_r;
        write_last_s  = write_last_r;
        word_s        = acc_r;
        word_lanes_s  = count_r;
        word_last_s   = 1'b0;
        complete_s    = 1'b0;
        timeout_s     = 1'b0;
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
        idle_s        = idle_r;
`endif

        case (state_r)
            FILL: begin
                if (accept_s) begin
                    // Unused lanes of acc_r are always zero, so only the target lane changes.
                    for (int i = 0; i < RATIO; i++) begin
                        if (count_r == LANE_W'(i)) begin
                            word_s[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
                        end else begin
                            word_s[i*IN_WIDTH +: IN_WIDTH] = acc_r[i*IN_WIDTH +: IN_WIDTH];
                        end
                    end
                    word_lanes_s = count_r + LANE_W'(1);
                    word_last_s  = bus.in_last;
                    complete_s   = bus.in_last || (count_r == LANE_W'(RATIO - 1));
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
                    idle_s = '0;
`endif
                end else begin
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
                    // This idle cycle is the TIMEOUT-th one: flush the partial word.
                    if (count_r != LANE_W'(0) && reset_poweron_n && !clear) begin
                        if (idle_r == IDLE_W'(TIMEOUT - 1)) begin
                            timeout_s = 1'b1;
                            idle_s    = '0;
                        end else begin
                            idle_s = idle_r + IDLE_W'(1);
                        end
                    end else begin
                        idle_s = '0;
                    end
`endif
                    complete_s = timeout_s;
                end

                if (complete_s) begin
                    count_s = '0;
                    acc_s   = '0;
                    if (!bus.almost_full) begin
                        write_s       = 1'b1;
                        write_data_s  = word_s;
                        write_lanes_s = word_lanes_s;
                        write_last_s  = word_last_s;
                    end else begin
                        state_s      = HOLD;
                        hold_data_s  = word_s;
                        hold_lanes_s = word_lanes_s;
                        hold_last_s  = word_last_s;
                    end
                end else if (accept_s) begin
                    count_s = word_lanes_s;
                    acc_s   = word_s;
                end else begin
                    count_s = count_r;
                end
            end
            HOLD: begin
                if (!bus.almost_full) begin
                    write_s       = 1'b1;
                    write_data_s  = hold_data_r;
                    write_lanes_s = hold_lanes_r;
                    write_last_s  = hold_last_r;
                    state_s       = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FILL;
                count_s = '0;
                acc_s   = '0;
            end
        endcase
    end

    // State and output registers; reset and clear discard everything, including a parked word.
    always_ff @(posedge clk) begin
        if (!reset_poweron_n || clear) begin
            state_r       <= FILL;
            count_r       <= '0;
            acc_r         <= '0;
            hold_data_r   <= '0;
            hold_lanes_r  <= '0;
            hold_last_r   <= 1'b0;
            write_r       <= 1'b0;
            write_data_r  <= '0;
            write_lanes_r <= '0;
            write_last_r  <= 1'b0;
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
            idle_r        <= '0;
`endif
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            acc_r         <= acc_s;
            hold_data_r   <= hold_data_s;
            hold_lanes_r  <= hold_lanes_s;
            hold_last_r   <= hold_last_s;
            write_r       <= write_s;
            write_data_r  <= write_data_s;
            write_lanes_r <= write_lanes_s;
            write_last_r  <= write_last_s;
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
            idle_r        <= idle_s;
`endif
        end
    end
endmodule

// File: tb/tb_generic_fifo_write_packer.sv
// Directed bench for generic_fifo_write_packer (IN_WIDTH=8, RATIO=4, TIMEOUT=16).
module tb_generic_fifo_write_packer;
    logic clk = 1'b0;
    logic reset_poweron_n;
    logic clear;
    int   n_cmp = 0;
    int   n_err = 0;

    generic_fifo_write_packer_if #(.IN_WIDTH(8), .RATIO(4)) bus ();

    generic_fifo_write_packer #(.IN_WIDTH(8), .RATIO(4), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset_poweron_n (reset_poweron_n),
        .clear           (clear),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [2:0] l, input logic last);
        check({tag, "_write"}, 64'(bus.write), 64'd1);
        check({tag, "_data"},  64'(bus.write_data), 64'(d));
        check({tag, "_lanes"}, 64'(bus.write_lanes), 64'(l));
        check({tag, "_last"},  64'(bus.write_last), 64'(last));
    endtask

    initial begin
        logic quiet;
        reset_poweron_n = 1'b0;
        clear           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_last     = 1'b0;
        bus.almost_full = 1'b0;
        step(); step(); step();

        // Reset state
        check("rst_write", 64'(bus.write), 64'd0);
        check("rst_data",  64'(bus.write_data), 64'd0);
        check("rst_lanes", 64'(bus.write_lanes), 64'd0);
        check("rst_last",  64'(bus.write_last), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd0);
        reset_poweron_n = 1'b1;
        #1;
        check("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // 1: full word, back-to-back
        beat(8'h11, 1'b0); check("t1_b1_nowrite", 64'(bus.write), 64'd0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0); check("t1_b3_nowrite", 64'(bus.write), 64'd0);
        beat(8'h44, 1'b0);
        check_word("t1", 32'h44332211, 3'd4, 1'b0);
        step();
        check("t1_pulse", 64'(bus.write), 64'd0);

        // 2: partial word on in_last, next beat starts at lane 0
        beat(8'hA1, 1'b0);
        beat(8'hB2, 1'b1);
        check_word("t2a", 32'h0000B2A1, 3'd2, 1'b1);
        beat(8'hC3, 1'b0);
        check("t2_c3_nowrite", 64'(bus.write), 64'd0);
        beat(8'hD4, 1'b1);
        check_word("t2b", 32'h0000D4C3, 3'd2, 1'b1);

        // 3: back-pressure at completion parks the word
        beat(8'h81, 1'b0);
        beat(8'h82, 1'b0);
        beat(8'h83, 1'b0);
        bus.almost_full = 1'b1;
        beat(8'h84, 1'b0);
        check("t3_hold_nowrite", 64'(bus.write), 64'd0);
        check("t3_hold_ready", 64'(bus.in_ready), 64'd0);
        quiet = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.write !== 1'b0 || bus.in_ready !== 1'b0) quiet = 1'b0;
        end
        check("t3_hold_quiet", 64'(quiet), 64'd1);
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.almost_full = 1'b0;
        step();
        check_word("t3", 32'h84838281, 3'd4, 1'b0);
        step();
        check("t3_pulse", 64'(bus.write), 64'd0);
        check("t3_ready_back", 64'(bus.in_ready), 64'd1);

        // 4: clear discards partial word and a same-cycle beat
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        beat(8'hCC, 1'b0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hDD;
        bus.in_last  = 1'b1;
        #1;
        check("t4_clear_ready", 64'(bus.in_ready), 64'd0);
        step();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("t4_clear_nowrite", 64'(bus.write), 64'd0);
        beat(8'h01, 1'b0); check("t4_b1_nowrite", 64'(bus.write), 64'd0);
        beat(8'h02, 1'b0); check("t4_b2_nowrite", 64'(bus.write), 64'd0);
        beat(8'h03, 1'b0); check("t4_b3_nowrite", 64'(bus.write), 64'd0);
        beat(8'h04, 1'b0);
        check_word("t4", 32'h04030201, 3'd4, 1'b0);

        // 5: reset during HOLD drops the parked word
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        bus.almost_full = 1'b1;
        beat(8'h03, 1'b1);
        check("t5_hold_nowrite", 64'(bus.write), 64'd0);
        reset_poweron_n = 1'b0;
        bus.almost_full = 1'b0;
        step();
        check("t5_rst_write", 64'(bus.write), 64'd0);
        check("t5_rst_data",  64'(bus.write_data), 64'd0);
        check("t5_rst_lanes", 64'(bus.write_lanes), 64'd0);
        check("t5_rst_last",  64'(bus.write_last), 64'd0);
        check("t5_rst_ready", 64'(bus.in_ready), 64'd0);
        reset_poweron_n = 1'b1;
        step();
        check("t5_post_nowrite", 64'(bus.write), 64'd0);
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b0);
        beat(8'h40, 1'b0);
        check_word("t5", 32'h40302010, 3'd4, 1'b0);
        step();

        // 6: idle partial word
        beat(8'h5A, 1'b0);
`ifdef GENERIC_FIFO_PACKER_TIMEOUT_EN
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.write !== 1'b0) quiet = 1'b0;
        end
        check("t6_idle_quiet", 64'(quiet), 64'd1);
        step();
        check_word("t6", 32'h0000005A, 3'd1, 1'b0);
`else
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.write !== 1'b0) quiet = 1'b0;
        end
        check("t6_idle_quiet", 64'(quiet), 64'd1);
        beat(8'h6B, 1'b1);
        check_word("t6", 32'h00006B5A, 3'd2, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
